ux607_reset_sequencer: RTL and testbench

Ordered reset-release sequencer that sits directly downstream of the reset catch-and-sync stage. It consumes that stage's synchronized, active-high reset and releases NUM_STAGES subsystem resets one at a time. Each release is spaced by a fixed cycle delay and gated by a per-stage ready acknowledge. It drives the peripheral/SRAM/debug reset tree so dependent blocks leave reset only after their prerequisites report ready.

---
 rtl/ux607_reset_sequencer_if.sv | 34 +++
 rtl/ux607_reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ux607_reset_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ux607_reset_sequencer_if.sv
// ux607_reset_sequencer_if
//   Groups the reset-sequencing signals between the sequencer and the
//   reset tree it drives.
//   sync_reset_in : synchronized active-high reset from catch-and-sync
//   stage_ack     : per-stage ready level, NUM_STAGES bits
//   stage_reset   : per-stage active-high reset, bit 0 released first
//   seq_done      : all stages released and acknowledged
//   seq_error     : sticky ack-timeout flag
//   Modports: master = sequencer side, slave = reset-tree/environment side.
interface ux607_reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  sync_reset_in;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_reset;
  logic                  seq_done;
  logic                  seq_error;

  modport master (
    input  sync_reset_in,
    input  stage_ack,
    output stage_reset,
    output seq_done,
    output seq_error
  );

  modport slave (
    output sync_reset_in,
    output stage_ack,
    input  stage_reset,
    input  seq_done,
    input  seq_error
  );
endinterface

// File: rtl/ux607_reset_sequencer.sv
// ux607_reset_sequencer
//   Ordered reset-release sequencer. Consumes the synchronized reset from the
//   catch-and-sync stage and releases NUM_STAGES subsystem resets one at a
//   time, each spaced by STAGE_DELAY cycles and gated by the previous stage's
//   ready acknowledge.
//   Ports:
//     clock : block clock
//     reset : asynchronous active-high reset of the sequencer
//     bus   : ux607_reset_sequencer_if.master (sync_reset_in, stage_ack in;
//             stage_reset, seq_done, seq_error out; all outputs registered)
//   Build option:
//     UX607_RSTSEQ_TIMEOUT_EN : when defined, an ack that stays low for
//     TIMEOUT WAIT_ACK edges sets the sticky seq_error and the sequence moves
//     on as if acked. When undefined, WAIT_ACK waits indefinitely and
//     seq_error is constant 0.
module ux607_reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned DELAY_W     = 8,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  ux607_reset_sequencer_if.master         bus
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(STAGE_DELAY - 1);

  // Elaboration-time parameter sanity checks.
  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $error("NUM_STAGES must be in 1..16");
  end
  if (STAGE_DELAY < 1 || STAGE_DELAY >= (64'd1 << DELAY_W)) begin : g_bad_delay
    $error("STAGE_DELAY must be in 1..2^DELAY_W-1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    HOLD,
    DELAY,
    WAIT_ACK,
    DONE
  } state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [DELAY_W-1:0]    dcnt, dcnt_d;
  logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                  done_q, done_d;
  logic                  ack;
  logic                  advance;

`ifdef UX607_RSTSEQ_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] tcnt, tcnt_d;
  logic              error_q, error_d;
`endif

  assign ack = bus.stage_ack[idx];

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    dcnt_d        = dcnt;
    stage_reset_d = stage_reset_q;
    done_d        = done_q;
    advance       = 1'b0;
`ifdef UX607_RSTSEQ_TIMEOUT_EN
    tcnt_d        = tcnt;
    error_d       = error_q;
`endif

    case (state)
      HOLD: begin
        if (!bus.sync_reset_in) begin
          dcnt_d  = DELAY_LOAD;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (dcnt != '0) begin
          dcnt_d = dcnt - 1'b1;
        end else begin
          stage_reset_d[idx] = 1'b0;
          state_d            = WAIT_ACK;
`ifdef UX607_RSTSEQ_TIMEOUT_EN
          tcnt_d             = '0;
`endif
        end
      end
      WAIT_ACK: begin
        advance = ack;
`ifdef UX607_RSTSEQ_TIMEOUT_EN
        if (!ack) begin
          if (tcnt == TCNT_LAST) begin
            error_d = 1'b1;
            advance = 1'b1;
          end else begin
            tcnt_d = tcnt + 1'b1;
          end
        end
`endif
        if (advance) begin
          if (idx == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx + 1'b1;
            dcnt_d  = DELAY_LOAD;
            state_d = DELAY;
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    // Reassertion of the upstream reset overrides any transition computed
    // above, including ack acceptance and timeout.
    if (bus.sync_reset_in && state != HOLD) begin
      state_d       = HOLD;
      idx_d         = '0;
      stage_reset_d = '1;
      done_d        = 1'b0;
`ifdef UX607_RSTSEQ_TIMEOUT_EN
      error_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= HOLD;
      idx           <= '0;
      dcnt          <= '0;
      stage_reset_q <= '1;
      done_q        <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      dcnt          <= dcnt_d;
      stage_reset_q <= stage_reset_d;
      done_q        <= done_d;
    end
  end

`ifdef UX607_RSTSEQ_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      error_q <= 1'b0;
    end else begin
      tcnt    <= tcnt_d;
      error_q <= error_d;
    end
  end

  assign bus.seq_error = error_q;
`else
  assign bus.seq_error = 1'b0;
`endif

  assign bus.stage_reset = stage_reset_q;
  assign bus.seq_done    = done_q;

endmodule

// File: tb/tb_ux607_reset_sequencer.sv
// tb_ux607_reset_sequencer
//   Scoreboard bench: each driven cycle feeds a timestamp-based reference
//   model whose expected outputs are queued; a negedge monitor pops and
//   compares them against the DUT. Directed phases cover the documented
//   timing points, followed by a randomized phase.
module tb_ux607_reset_sequencer;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int TO = 8;

`ifdef UX607_RSTSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ux607_reset_sequencer_if #(.NUM_STAGES(N)) bus ();

  ux607_reset_sequencer #(
    .NUM_STAGES (N),
    .STAGE_DELAY(D),
    .DELAY_W    (8),
    .TIMEOUT    (TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [N-1:0] sr;
    logic         done;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: expressed as absolute edge times of upcoming events.
  int           t = 0;
  logic [N-1:0] m_rst;
  bit           m_done, m_err, m_hold, m_wait;
  int           m_cur, m_next, m_wstart;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
  endtask

  function automatic void model_init();
    m_rst    = '1;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_hold   = 1'b1;
    m_wait   = 1'b0;
    m_cur    = 0;
    m_next   = 0;
    m_wstart = 0;
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic [N-1:0] a);
    bit   go;
    exp_t e;
    t++;
    if (r || s) begin
      model_init();
    end else if (m_hold) begin
      m_hold = 1'b0;
      m_next = t + D;
    end else if (m_done) begin
      // finished: nothing changes
    end else if (!m_wait) begin
      if (t == m_next) begin
        m_rst[m_cur] = 1'b0;
        m_wait       = 1'b1;
        m_wstart     = t;
      end
    end else begin
      go = a[m_cur] || (TO_EN && (t - m_wstart) == TO);
      if (go && !a[m_cur]) m_err = 1'b1;
      if (go) begin
        if (m_cur == N - 1) begin
          m_done = 1'b1;
        end else begin
          m_cur++;
          m_wait = 1'b0;
          m_next = t + D;
        end
      end
    end
    e.sr   = m_rst;
    e.done = m_done;
    e.err  = m_err;
    exp_q.push_back(e);
  endfunction

  // Drive one cycle: inputs change 1 time unit after the previous edge.
  task automatic cyc(input logic s, input logic [N-1:0] a);
    bus.sync_reset_in = s;
    bus.stage_ack     = a;
    @(posedge clock);
    model_step(reset, s, a);
    #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stage_reset", 32'(bus.stage_reset), 32'(e.sr));
      chk("seq_done",    32'(bus.seq_done),    32'(e.done));
      chk("seq_error",   32'(bus.seq_error),   32'(e.err));
    end
  end

  initial begin
    int pulse;
    logic s;
    model_init();
    bus.sync_reset_in = 1'b1;
    bus.stage_ack     = '0;

    // Sequencer reset, then upstream reset held for 50 cycles.
    repeat (3) cyc(1'b1, '0);
    reset = 1'b0;
    repeat (50) cyc(1'b1, N'($urandom));
    chk("hold_stage_reset", 32'(bus.stage_reset), 32'hF);

    // Acks tied high: releases at E0+16/33/50/67, done at E0+68.
    cyc(1'b0, '1);
    for (int k = 1; k <= 68; k++) begin
      cyc(1'b0, '1);
      if (k == 15) chk("e0p15_sr", 32'(bus.stage_reset), 32'hF);
      if (k == 16) chk("e0p16_sr", 32'(bus.stage_reset), 32'hE);
      if (k == 33) chk("e0p33_sr", 32'(bus.stage_reset), 32'hC);
      if (k == 50) chk("e0p50_sr", 32'(bus.stage_reset), 32'h8);
      if (k == 67) chk("e0p67_done", 32'(bus.seq_done), 32'h0);
      if (k == 68) chk("e0p68_done", 32'(bus.seq_done), 32'h1);
    end
    repeat (5) cyc(1'b0, '0);
    chk("done_ignores_ack_drop", 32'(bus.seq_done), 32'h1);

    // Stage 1 ack held low for 100 cycles after its release.
    cyc(1'b1, '1);
    chk("reassert_from_done_sr", 32'(bus.stage_reset), 32'hF);
    cyc(1'b0, 4'b1101);
    for (int k = 1; k <= 33; k++) cyc(1'b0, 4'b1101);
    chk("stage1_released", 32'(bus.stage_reset), 32'hC);
    repeat (100) cyc(1'b0, 4'b1101);
    chk("stage2_held", 32'(bus.stage_reset), 32'hC);
    cyc(1'b0, '1);
    for (int j = 1; j <= 16; j++) begin
      cyc(1'b0, '1);
      if (j == 15) chk("a_p15_sr", 32'(bus.stage_reset), 32'hC);
      if (j == 16) chk("a_p16_sr", 32'(bus.stage_reset), 32'h8);
    end

    // Reassert while idx = 2 in DELAY, then restart from stage 0.
    cyc(1'b1, '1);
    cyc(1'b0, '1);
    for (int k = 1; k <= 40; k++) cyc(1'b0, '1);
    chk("mid_delay_sr", 32'(bus.stage_reset), 32'hC);
    cyc(1'b1, '1);
    chk("reassert_sr",   32'(bus.stage_reset), 32'hF);
    chk("reassert_done", 32'(bus.seq_done),    32'h0);
    cyc(1'b0, '1);
    for (int k = 1; k <= 16; k++) cyc(1'b0, '1);
    chk("restart_stage0", 32'(bus.stage_reset), 32'hE);

    // Acks held low: timeout advance or stall, depending on the build.
    cyc(1'b1, '0);
    cyc(1'b0, '0);
    repeat (110) cyc(1'b0, '0);
    if (TO_EN) begin
      chk("timeout_done",  32'(bus.seq_done),  32'h1);
      chk("timeout_error", 32'(bus.seq_error), 32'h1);
    end else begin
      chk("stall_sr",    32'(bus.stage_reset), 32'hE);
      chk("stall_error", 32'(bus.seq_error),   32'h0);
    end

    // Asynchronous reset mid-sequence, asserted between edges.
    cyc(1'b1, '1);
    cyc(1'b0, '1);
    repeat (40) cyc(1'b0, '1);
    #5;
    reset = 1'b1;
    #1;
    chk("async_sr",    32'(bus.stage_reset), 32'hF);
    chk("async_done",  32'(bus.seq_done),    32'h0);
    chk("async_error", 32'(bus.seq_error),   32'h0);
    repeat (2) cyc(1'b1, '1);
    reset = 1'b0;

    // Randomized phase: sparse upstream reset pulses, sparse acks.
    pulse = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pulse == 0 && $urandom_range(0, 149) == 0) pulse = $urandom_range(1, 4);
      s = (pulse > 0);
      if (pulse > 0) pulse--;
      cyc(s, N'($urandom & $urandom));
    end

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
